spi_xfer_sequencer: RTL and testbench

//  Bus master that drives the spi_bonus register port (addr 0 TX write, addr 1 RX FIFO pop, addr 2 status).

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_seq_buf.sv | 24 ++
 rtl/spi_xfer_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the spi_bonus register port and the masters that drive it.
package spi_pkg;

    localparam logic [1:0] SPI_ADDR_TX   = 2'd0;
    localparam logic [1:0] SPI_ADDR_RX   = 2'd1;
    localparam logic [1:0] SPI_ADDR_STAT = 2'd2;
    localparam int         SPI_STAT_RDY  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/spi_seq_buf.sv
// DEPTH x 8 byte buffer: synchronous write port, asynchronous read port.
module spi_seq_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [7:0]               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [7:0]               rdata
);

    logic [7:0] mem_r [DEPTH];

    // Byte write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Streams a preloaded TX buffer through the spi_bonus register port and collects
// the looped-back bytes into an RX buffer, with a bounded number of bytes in flight.
module spi_xfer_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     tx_we,
    input  logic [$clog2(DEPTH)-1:0] tx_waddr,
    input  logic [7:0]               tx_wdata,
    input  logic [$clog2(DEPTH)-1:0] rx_raddr,
    output logic [7:0]               rx_rdata,
    output logic [7:0]               spi_din,
    input  logic [7:0]               spi_dout,
    output logic                     spi_wren,
    output logic                     spi_rden,
    output logic [1:0]               spi_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int PW = $clog2(TIMEOUT);
    localparam logic [LW-1:0] DEPTH_C   = LW'(DEPTH);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [PW-1:0] POLL_LAST = PW'(TIMEOUT - 1);

    seq_state_e    state_r, state_s;
    logic [LW-1:0] len_r, len_s;
    logic [LW-1:0] wr_idx_r, wr_idx_s;
    logic [LW-1:0] rd_idx_r, rd_idx_s;
    logic [OW-1:0] out_r, out_s;
    logic [PW-1:0] poll_r, poll_s;
    logic          err_r, err_s;
    logic          rx_we_s;
    logic [7:0]    tx_rdata_s;

    // TX writes are only accepted while idle so a running transfer sees stable data
    spi_seq_buf #(.DEPTH(DEPTH)) u_tx_buf (
        .clk   (clk),
        .we    (tx_we && (state_r == ST_IDLE)),
        .waddr (tx_waddr),
        .wdata (tx_wdata),
        .raddr (wr_idx_r[AW-1:0]),
        .rdata (tx_rdata_s)
    );

    spi_seq_buf #(.DEPTH(DEPTH)) u_rx_buf (
        .clk   (clk),
        .we    (rx_we_s),
        .waddr (rd_idx_r[AW-1:0]),
        .wdata (spi_dout),
        .raddr (rx_raddr),
        .rdata (rx_rdata)
    );

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            len_r    <= '0;
            wr_idx_r <= '0;
            rd_idx_r <= '0;
            out_r    <= '0;
            poll_r   <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            len_r    <= len_s;
            wr_idx_r <= wr_idx_s;
            rd_idx_r <= rd_idx_s;
            out_r    <= out_s;
            poll_r   <= poll_s;
            err_r    <= err_s;
        end
    end

    // Next-state, counter updates and bus decode; writes win over status polls
    always_comb begin
        state_s  = state_r;
        len_s    = len_r;
        wr_idx_s = wr_idx_r;
        rd_idx_s = rd_idx_r;
        out_s    = out_r;
        poll_s   = poll_r;
        err_s    = err_r;
        rx_we_s  = 1'b0;
        spi_wren = 1'b0;
        spi_rden = 1'b0;
        spi_addr = SPI_ADDR_TX;
        spi_din  = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_s = 1'b0;
                    if (len != '0) begin
                        len_s    = (len > DEPTH_C) ? DEPTH_C : len;
                        wr_idx_s = '0;
                        rd_idx_s = '0;
                        out_s    = '0;
                        poll_s   = '0;
                        state_s  = ST_XFER;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if ((wr_idx_r < len_r) && (out_r < MAX_OUT_C)) begin
                    spi_wren = 1'b1;
                    spi_addr = SPI_ADDR_TX;
                    spi_din  = tx_rdata_s;
                    wr_idx_s = wr_idx_r + LW'(1);
                    out_s    = out_r + OW'(1);
                end else begin
                    spi_rden = 1'b1;
                    spi_addr = SPI_ADDR_STAT;
                    if (spi_dout[SPI_STAT_RDY]) begin
                        poll_s  = '0;
                        state_s = ST_READ;
                    end else if (poll_r == POLL_LAST) begin
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        poll_s = poll_r + PW'(1);
                    end
                end
            end
            ST_READ: begin
                spi_rden = 1'b1;
                spi_addr = SPI_ADDR_RX;
                rx_we_s  = 1'b1;
                rd_idx_s = rd_idx_r + LW'(1);
                out_s    = out_r - OW'(1);
                if (rd_idx_r == (len_r - LW'(1))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_r != ST_IDLE);
    assign done = (state_r == ST_DONE);
    assign err  = err_r;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural loopback SPI peripheral.
module tb_spi_xfer_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, tx_we;
    logic [4:0] len;
    logic [3:0] tx_waddr, rx_raddr;
    logic [7:0] tx_wdata, rx_rdata, spi_din, spi_dout;
    logic       busy, done, err, spi_wren, spi_rden;
    logic [1:0] spi_addr;

    logic invert, stub, prst, mon_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_xfer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .tx_we(tx_we), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
        .rx_raddr(rx_raddr), .rx_rdata(rx_rdata),
        .spi_din(spi_din), .spi_dout(spi_dout),
        .spi_wren(spi_wren), .spi_rden(spi_rden), .spi_addr(spi_addr)
    );

    // Peripheral model: TX FIFO -> 8-cycle shifter -> (optionally inverted) RX FIFO
    logic [7:0] ptx [16];
    logic [7:0] prx [16];
    logic [3:0] ptx_w, ptx_r, prx_w, prx_r, sh_cnt;
    logic       sh_busy;
    logic [7:0] sh_byte;
    logic       rdy;

    always @(posedge clk) begin
        if (prst) begin
            ptx_w <= 4'd0; ptx_r <= 4'd0; prx_w <= 4'd0; prx_r <= 4'd0;
            sh_busy <= 1'b0; sh_cnt <= 4'd0; sh_byte <= 8'h00;
        end else begin
            if (spi_wren && spi_addr == 2'd0) begin
                ptx[ptx_w] <= spi_din;
                ptx_w <= ptx_w + 4'd1;
            end
            if (spi_rden && spi_addr == 2'd1 && prx_w != prx_r) prx_r <= prx_r + 4'd1;
            if (sh_busy) begin
                if (sh_cnt == 4'd0) begin
                    prx[prx_w] <= invert ? ~sh_byte : sh_byte;
                    prx_w <= prx_w + 4'd1;
                    sh_busy <= 1'b0;
                end else begin
                    sh_cnt <= sh_cnt - 4'd1;
                end
            end else if (ptx_w != ptx_r) begin
                sh_byte <= ptx[ptx_r];
                ptx_r <= ptx_r + 4'd1;
                sh_cnt <= 4'd7;
                sh_busy <= 1'b1;
            end
        end
    end

    assign rdy = (prx_w != prx_r) && !stub;

    always_comb begin
        spi_dout = 8'h00;
        if (spi_addr == 2'd2) spi_dout = {6'd0, rdy, 1'b0};
        else if (spi_addr == 2'd1) spi_dout = prx[prx_r];
    end

    // Bus monitor, sampled on the falling edge
    logic [7:0] wr_log [16];
    int wr_n, polls, bus_ops, done_n, mon_out, out_viol, both_viol;

    always @(negedge clk) begin
        if (mon_clr || reset) begin
            wr_n <= 0; polls <= 0; bus_ops <= 0; done_n <= 0;
            mon_out <= 0; out_viol <= 0; both_viol <= 0;
        end else begin
            if (spi_wren && spi_rden) both_viol <= both_viol + 1;
            if (spi_wren || spi_rden) bus_ops <= bus_ops + 1;
            if (done) done_n <= done_n + 1;
            if (spi_rden && spi_addr == 2'd2) polls <= polls + 1;
            if (spi_wren && spi_addr == 2'd0) begin
                if (wr_n < 16) wr_log[wr_n] <= spi_din;
                wr_n <= wr_n + 1;
                if (mon_out + 1 > 4) out_viol <= out_viol + 1;
                mon_out <= mon_out + 1;
            end else if (spi_rden && spi_addr == 2'd1) begin
                mon_out <= mon_out - 1;
            end
        end
    end

    typedef struct {
        logic         inv;
        logic [4:0]   len;
        logic [127:0] tx;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic periph_reset();
        prst = 1'b1;
        tick();
        prst = 1'b0;
    endtask

    task automatic load_tx(input logic [127:0] data);
        for (int i = 0; i < 16; i++) begin
            tx_we = 1'b1; tx_waddr = 4'(i); tx_wdata = data[i*8 +: 8];
            tick();
        end
        tx_we = 1'b0;
    endtask

    task automatic start_xfer(input logic [4:0] l);
        start = 1'b1; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_rx(input string nm, input int idx, input logic [7:0] req);
        rx_raddr = 4'(idx);
        #1;
        check(nm, {24'd0, rx_rdata}, {24'd0, req});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int eff, nw;
        reset = 1'b1; start = 1'b0; len = 5'd0; tx_we = 1'b0; tx_waddr = 4'd0; tx_wdata = 8'h00;
        rx_raddr = 4'd0; invert = 1'b0; stub = 1'b0; prst = 1'b1; mon_clr = 1'b0;

        vecs[0] = '{inv: 1'b0, len: 5'd3,  tx: 128'h386255, exp: 128'h386255};
        vecs[1] = '{inv: 1'b1, len: 5'd3,  tx: 128'h2CF3A9, exp: 128'hD30C56};
        vecs[2] = '{inv: 1'b0, len: 5'd16, tx: 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
                                           exp: 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0};
        vecs[3] = '{inv: 1'b1, len: 5'd1,  tx: 128'hFF, exp: 128'h00};
        vecs[4] = '{inv: 1'b1, len: 5'd20, tx: 128'h0123456789ABCDEFFEDCBA9876543210,
                                           exp: 128'hFEDCBA98765432100123456789ABCDEF};

        repeat (3) tick();
        reset = 1'b0; prst = 1'b0;
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err",  {31'd0, err},  32'd0);
        check("reset_bus",  {29'd0, spi_wren, spi_rden, spi_addr == 2'd0}, 32'd1);
        check("reset_din",  {24'd0, spi_din}, 32'd0);

        // Table-driven loopback transfers
        for (int v = 0; v < 5; v++) begin
            invert = vecs[v].inv;
            periph_reset();
            mon_reset();
            load_tx(vecs[v].tx);
            start_xfer(vecs[v].len);
            check("busy_after_start", {31'd0, busy}, 32'd1);
            wait_done(2000, seen);
            check("done_seen", {31'd0, seen}, 32'd1);
            check("err_at_done", {31'd0, err}, 32'd0);
            tick();
            check("idle_after_done", {31'd0, busy}, 32'd0);
            eff = (vecs[v].len > 5'd16) ? 16 : int'(vecs[v].len);
            check("write_count", wr_n, eff);
            for (int i = 0; i < eff; i++) begin
                check("mosi_byte", {24'd0, wr_log[i]}, {24'd0, vecs[v].tx[i*8 +: 8]});
                check_rx("rx_byte", i, vecs[v].exp[i*8 +: 8]);
            end
            check("done_pulses", done_n, 1);
            check("polls_ge_len", {31'd0, polls >= eff}, 32'd1);
            check("max_outstanding", out_viol, 0);
            check("wren_and_rden", both_viol, 0);
        end

        // Zero-length transfer: immediate done, no bus activity
        mon_reset();
        start_xfer(5'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd1);
        tick();
        check("len0_done_off", {31'd0, done}, 32'd0);
        check("len0_busy_off", {31'd0, busy}, 32'd0);
        tick();
        check("len0_bus_ops", bus_ops, 0);
        check("len0_done_pulses", done_n, 1);

        // Timeout with a peripheral that never reports ready
        invert = 1'b0;
        periph_reset();
        stub = 1'b1;
        mon_reset();
        load_tx(128'hA5);
        start_xfer(5'd1);
        wait_done(6000, seen);
        check("timeout_done", {31'd0, seen}, 32'd1);
        check("timeout_err", {31'd0, err}, 32'd1);
        tick();
        check("timeout_polls", polls, 4096);
        check("timeout_err_held", {31'd0, err}, 32'd1);
        stub = 1'b0;
        periph_reset();
        start_xfer(5'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
        tx_we = 1'b1; tx_waddr = 4'd0; tx_wdata = 8'hEE;
        tick();
        tx_we = 1'b0;
        wait_done(500, seen);
        check("retry_done", {31'd0, seen}, 32'd1);
        check("retry_err", {31'd0, err}, 32'd0);
        tick();
        check_rx("retry_rx", 0, 8'hA5);
        invert = 1'b1;
        periph_reset();
        start_xfer(5'd1);
        wait_done(500, seen);
        check("busy_write_dropped_done", {31'd0, seen}, 32'd1);
        tick();
        check_rx("busy_write_dropped", 0, 8'h5A);

        // Reset during the third write of an 8-byte transfer
        invert = 1'b0;
        periph_reset();
        mon_reset();
        load_tx(128'h0807060504030201);
        start_xfer(5'd8);
        nw = 0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (spi_wren && spi_addr == 2'd0) nw++;
            if (nw == 3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("third_write_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        tick();
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_err",  {31'd0, err},  32'd0);
        check("midreset_wren", {31'd0, spi_wren}, 32'd0);
        check("midreset_rden", {31'd0, spi_rden}, 32'd0);
        check("midreset_addr", {30'd0, spi_addr}, 32'd0);
        check("midreset_din",  {24'd0, spi_din}, 32'd0);
        reset = 1'b0;
        periph_reset();
        mon_reset();
        load_tx(128'h3CC3);
        start_xfer(5'd2);
        wait_done(500, seen);
        check("post_reset_done", {31'd0, seen}, 32'd1);
        check("post_reset_err", {31'd0, err}, 32'd0);
        tick();
        check_rx("post_reset_rx0", 0, 8'hC3);
        check_rx("post_reset_rx1", 1, 8'h3C);
        check("post_reset_done_pulses", done_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
